// File: rtl/muldiv_pkg.sv
// Shared definitions for the HI/LO multiply/divide sequencer.
//   ALU_*     : function codes understood by the shared 32-bit ALU
//   op_e      : mul/div opcode as presented on the 'op' port
//   state_e   : sequencer states
//   twos_neg  : wide two's-complement negate; callers zero-extend to NEG_W
//               and keep the low bits they need.
package muldiv_pkg;

  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

  // Wide enough for a 2*WIDTH product negate with WIDTH up to 64.
  localparam int unsigned NEG_W = 128;

  typedef enum logic [1:0] {
    MULTU = 2'b00,
    MULT  = 2'b01,
    DIVU  = 2'b10,
    DIV   = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    IDLE,
    PREP,
    ITER,
    FIX
  } state_e;

  function automatic logic [NEG_W-1:0] twos_neg(input logic [NEG_W-1:0] v);
    return ~v + NEG_W'(1);
  endfunction

endpackage

// File: rtl/muldiv_ctrl.sv
// Iterative MULT/MULTU/DIV/DIVU sequencer owning the HI/LO registers.
// One add (multiply) or subtract (divide) per cycle on the external ALU.
//   CLK, RST          : clock, asynchronous active-high reset
//   start, op         : issue request and opcode (sampled only when idle)
//   rs_val, rt_val    : multiplicand/dividend, multiplier/divisor
//   mthi, mtlo, wdata : direct HI/LO writes, honoured only when idle
//   busy, done        : operation in progress / one-cycle completion pulse
//   hi, lo            : architectural HI/LO
//   div_by_zero       : sticky, set by divide with rt=0, cleared on next start
//   alu_a/b/f         : ALU operands and function (from registered state only)
//   alu_y, alu_cout   : ALU result and carry-out
module muldiv_ctrl
  import muldiv_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] rs_val,
  input  logic [WIDTH-1:0] rt_val,
  input  logic             mthi,
  input  logic             mtlo,
  input  logic [WIDTH-1:0] wdata,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             div_by_zero,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [2:0]       alu_f,
  input  logic [WIDTH-1:0] alu_y,
  input  logic             alu_cout
);

  localparam int unsigned CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  function automatic logic [WIDTH-1:0] neg_w(input logic [WIDTH-1:0] v);
    logic [NEG_W-1:0] t;
    t = twos_neg(NEG_W'(v));
    return t[WIDTH-1:0];
  endfunction

  function automatic logic [2*WIDTH-1:0] neg_2w(input logic [2*WIDTH-1:0] v);
    logic [NEG_W-1:0] t;
    t = twos_neg(NEG_W'(v));
    return t[2*WIDTH-1:0];
  endfunction

  state_e           state_q, state_d;
  op_e              op_q, op_d;
  logic [WIDTH-1:0] rs_q, rs_d, rt_q, rt_d;
  logic [WIDTH-1:0] mag_q, mag_d;   // multiplicand or divisor magnitude
  logic [WIDTH-1:0] acc_q, acc_d;   // product high half or remainder
  logic [WIDTH-1:0] quo_q, quo_d;   // multiplier shifting out / quotient shifting in
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             negq_q, negq_d, negr_q, negr_d;
  logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d;
  logic             busy_q, busy_d, done_q, done_d, dbz_q, dbz_d;

  logic             is_div, rs_sgn, rt_sgn, msb_out, qbit;
  logic [WIDTH-1:0] rs_mag, rt_mag, div_s;

  assign is_div  = (op_q == DIVU) || (op_q == DIV);
  assign rs_sgn  = ((op_q == MULT) || (op_q == DIV)) && rs_q[WIDTH-1];
  assign rt_sgn  = ((op_q == MULT) || (op_q == DIV)) && rt_q[WIDTH-1];
  assign rs_mag  = rs_sgn ? neg_w(rs_q) : rs_q;
  assign rt_mag  = rt_sgn ? neg_w(rt_q) : rt_q;
  // Restoring-divide step: the bit shifted out of rem means the true partial
  // remainder is >= 2^WIDTH, so the subtract always succeeds regardless of cout.
  assign div_s   = {acc_q[WIDTH-2:0], quo_q[WIDTH-1]};
  assign msb_out = acc_q[WIDTH-1];
  assign qbit    = alu_cout | msb_out;

  always_comb begin
    alu_f = ALU_AND;
    alu_a = '0;
    alu_b = '0;
    if (state_q == ITER) begin
      if (is_div) begin
        alu_f = ALU_SUB;
        alu_a = div_s;
        alu_b = mag_q;
      end else begin
        alu_f = ALU_ADD;
        alu_a = acc_q;
        alu_b = quo_q[0] ? mag_q : '0;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    rs_d    = rs_q;
    rt_d    = rt_q;
    mag_d   = mag_q;
    acc_d   = acc_q;
    quo_d   = quo_q;
    cnt_d   = cnt_q;
    negq_d  = negq_q;
    negr_d  = negr_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    dbz_d   = dbz_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          op_d    = op_e'(op);
          rs_d    = rs_val;
          rt_d    = rt_val;
          dbz_d   = 1'b0;
          busy_d  = 1'b1;
          state_d = PREP;
        end else begin
          if (mthi) hi_d = wdata;
          if (mtlo) lo_d = wdata;
        end
      end
      PREP: begin
        negq_d = rs_sgn ^ rt_sgn;
        negr_d = rs_sgn;
        if (is_div && (rt_q == '0)) begin
          hi_d    = rs_q;
          lo_d    = '1;
          dbz_d   = 1'b1;
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = IDLE;
        end else begin
          acc_d   = '0;
          cnt_d   = '0;
          quo_d   = is_div ? rs_mag : rt_mag;
          mag_d   = is_div ? rt_mag : rs_mag;
          state_d = ITER;
        end
      end
      ITER: begin
        if (is_div) begin
          acc_d = qbit ? alu_y : div_s;
          quo_d = {quo_q[WIDTH-2:0], qbit};
        end else begin
          // {acc,q} <= {cout, y, q} >> 1
          acc_d = {alu_cout, alu_y[WIDTH-1:1]};
          quo_d = {alu_y[0], quo_q[WIDTH-1:1]};
        end
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST) state_d = FIX;
      end
      FIX: begin
        if (is_div) begin
          lo_d = negq_q ? neg_w(quo_q) : quo_q;
          hi_d = negr_q ? neg_w(acc_q) : acc_q;
        end else begin
          {hi_d, lo_d} = negq_q ? neg_2w({acc_q, quo_q}) : {acc_q, quo_q};
        end
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= IDLE;
      op_q    <= MULTU;
      rs_q    <= '0;
      rt_q    <= '0;
      mag_q   <= '0;
      acc_q   <= '0;
      quo_q   <= '0;
      cnt_q   <= '0;
      negq_q  <= 1'b0;
      negr_q  <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      rs_q    <= rs_d;
      rt_q    <= rt_d;
      mag_q   <= mag_d;
      acc_q   <= acc_d;
      quo_q   <= quo_d;
      cnt_q   <= cnt_d;
      negq_q  <= negq_d;
      negr_q  <= negr_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      dbz_q   <= dbz_d;
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign hi          = hi_q;
  assign lo          = lo_q;
  assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Bench for muldiv_ctrl: behavioural ALU, reference model feeding a
// scoreboard queue, and a done-driven monitor that pops and compares.
module tb_muldiv_ctrl;
  import muldiv_pkg::*;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        start = 1'b0;
  logic [1:0]  op = 2'b00;
  logic [31:0] rs_val = '0, rt_val = '0, wdata = '0;
  logic        mthi = 1'b0, mtlo = 1'b0;
  logic        busy, done, div_by_zero, alu_cout;
  logic [31:0] hi, lo, alu_a, alu_b, alu_y;
  logic [2:0]  alu_f;

  muldiv_ctrl #(.WIDTH(32)) dut (
    .CLK(CLK), .RST(RST), .start(start), .op(op), .rs_val(rs_val), .rt_val(rt_val),
    .mthi(mthi), .mtlo(mtlo), .wdata(wdata), .busy(busy), .done(done), .hi(hi), .lo(lo),
    .div_by_zero(div_by_zero), .alu_a(alu_a), .alu_b(alu_b), .alu_f(alu_f),
    .alu_y(alu_y), .alu_cout(alu_cout)
  );

  always #5 CLK = ~CLK;

  // External ALU as the parent would provide it.
  always_comb begin
    case (alu_f)
      ALU_ADD: {alu_cout, alu_y} = {1'b0, alu_a} + {1'b0, alu_b};
      ALU_SUB: {alu_cout, alu_y} = {1'b0, alu_a} + {1'b0, ~alu_b} + 33'd1;
      default: {alu_cout, alu_y} = {1'b0, alu_a & alu_b};
    endcase
  end

  int unsigned vectors = 0, miscompares = 0, cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dbz;
    int unsigned lat;  // rising edges after the accepting edge until done is seen
    int unsigned t0;
  } exp_t;
  exp_t exp_q[$];
  exp_t mon_e;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic exp_t model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    exp_t e;
    longint sa, sv;
    logic [63:0] p;
    e.dbz = 1'b0;
    e.lat = 34;
    e.t0  = 0;
    e.hi  = '0;
    e.lo  = '0;
    sa = $signed(a);
    sv = $signed(b);
    case (o)
      2'b00: begin p = {32'b0, a} * {32'b0, b}; e.hi = p[63:32]; e.lo = p[31:0]; end
      2'b01: begin p = sa * sv; e.hi = p[63:32]; e.lo = p[31:0]; end
      default: begin
        if (b == 32'd0) begin
          e.hi = a; e.lo = 32'hFFFF_FFFF; e.dbz = 1'b1; e.lat = 1;
        end else if (o == 2'b10) begin
          e.lo = a / b; e.hi = a % b;
        end else begin
          p = sa / sv; e.lo = p[31:0];
          p = sa % sv; e.hi = p[31:0];
        end
      end
    endcase
    return e;
  endfunction

  always @(negedge CLK) begin
    if (!RST && done) begin
      if (exp_q.size() == 0) begin
        chk("spurious_done", 64'(done), 64'(0));
      end else begin
        mon_e = exp_q.pop_front();
        chk("hi", 64'(hi), 64'(mon_e.hi));
        chk("lo", 64'(lo), 64'(mon_e.lo));
        chk("div_by_zero", 64'(div_by_zero), 64'(mon_e.dbz));
        chk("latency", 64'(cyc - mon_e.t0), 64'(mon_e.lat));
        chk("busy_at_done", 64'(busy), 64'(0));
      end
    end
  end

  task automatic issue(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                       input logic with_mthi);
    exp_t e;
    @(negedge CLK);
    start = 1'b1; op = o; rs_val = a; rt_val = b;
    if (with_mthi) begin mthi = 1'b1; wdata = 32'hDEAD_BEEF; end
    @(negedge CLK);
    start = 1'b0; mthi = 1'b0;
    e = model(o, a, b);
    e.t0 = cyc;
    exp_q.push_back(e);
  endtask

  task automatic wait_done(input string tag);
    bit seen = 1'b0;
    for (int i = 0; i < 60 && !seen; i++) begin
      @(negedge CLK);
      if (done) seen = 1'b1;
      else chk({tag, "_busy"}, 64'(busy), 64'(1));
    end
    if (!seen) chk({tag, "_timeout"}, 64'(done), 64'(1));
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_hi"}, 64'(hi), 64'(0));
    chk({tag, "_lo"}, 64'(lo), 64'(0));
    chk({tag, "_busy"}, 64'(busy), 64'(0));
    chk({tag, "_done"}, 64'(done), 64'(0));
    chk({tag, "_dbz"}, 64'(div_by_zero), 64'(0));
    chk({tag, "_alu_a"}, 64'(alu_a), 64'(0));
    chk({tag, "_alu_b"}, 64'(alu_b), 64'(0));
    chk({tag, "_alu_f"}, 64'(alu_f), 64'(ALU_AND));
  endtask

  initial begin
    bit seen;
    logic [1:0]  ro;
    logic [31:0] ra, rb;

    repeat (2) @(negedge CLK);
    chk_reset_vals("rst");
    RST = 1'b0;
    @(negedge CLK);
    chk_reset_vals("post_rst");

    // Idle MTHI / MTLO
    mthi = 1'b1; wdata = 32'hA5A5_A5A5;
    @(negedge CLK);
    mthi = 1'b0;
    chk("mthi_idle", 64'(hi), 64'(32'hA5A5_A5A5));
    mtlo = 1'b1; wdata = 32'h5A5A_5A5A;
    @(negedge CLK);
    mtlo = 1'b0;
    chk("mtlo_idle", 64'(lo), 64'(32'h5A5A_5A5A));

    // MULTU with an ignored second start and a dropped MTHI while busy
    issue(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    seen = 1'b0;
    for (int k = 1; k <= 60 && !seen; k++) begin
      @(negedge CLK);
      if (done) begin
        seen = 1'b1;
      end else begin
        chk("multu_busy", 64'(busy), 64'(1));
        if (k == 5) chk("multu_alu_f", 64'(alu_f), 64'(ALU_ADD));
        if (k == 10) begin start = 1'b1; op = 2'b10; rs_val = 32'd1; rt_val = 32'd0; end
        if (k == 11) start = 1'b0;
        if (k == 12) begin mthi = 1'b1; wdata = 32'h1234_5678; end
        if (k == 13) begin
          mthi = 1'b0;
          chk("mthi_busy_dropped", 64'(hi), 64'(32'hA5A5_A5A5));
        end
      end
    end
    if (!seen) chk("multu_timeout", 64'(done), 64'(1));
    repeat (3) @(negedge CLK);
    chk("ignored_start_dbz", 64'(div_by_zero), 64'(0));

    issue(2'b01, 32'hFFFF_FFFD, 32'd5, 1'b0);          wait_done("mult_neg");
    issue(2'b11, 32'hFFFF_FFF9, 32'd2, 1'b0);          wait_done("div_neg");
    issue(2'b10, 32'd100, 32'd7, 1'b1);
    chk("start_beats_mthi", 64'(hi), 64'(32'hFFFF_FFFF));
    wait_done("divu_small");
    issue(2'b10, 32'hFFFF_FFFF, 32'h8000_0000, 1'b0);  wait_done("divu_msbout");
    issue(2'b11, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);  wait_done("div_ovf");
    issue(2'b10, 32'h0000_1234, 32'd0, 1'b0);          wait_done("divu_zero");

    // Next start clears the sticky flag; reset mid-operation aborts it
    issue(2'b11, 32'hFFFF_FFF9, 32'd2, 1'b0);
    chk("dbz_cleared", 64'(div_by_zero), 64'(0));
    for (int k = 1; k <= 19; k++) begin
      @(negedge CLK);
      chk("div_pre_rst_busy", 64'(busy), 64'(1));
      if (k == 10) begin
        chk("div_alu_f", 64'(alu_f), 64'(ALU_SUB));
        chk("div_alu_b", 64'(alu_b), 64'(2));
      end
    end
    @(posedge CLK);
    #2 RST = 1'b1;
    #1 chk_reset_vals("async_rst");
    void'(exp_q.pop_back());
    @(negedge CLK);
    RST = 1'b0;
    repeat (3) begin
      @(negedge CLK);
      chk("no_done_after_rst", 64'(done), 64'(0));
    end
    issue(2'b11, 32'hFFFF_FFF9, 32'd2, 1'b0);          wait_done("div_after_rst");

    for (int i = 0; i < 8; i++) begin
      ro = 2'($urandom_range(0, 3));
      ra = $urandom;
      rb = (i == 3) ? 32'd0 : ($urandom >> $urandom_range(0, 31));
      issue(ro, ra, rb, 1'b0);
      wait_done("rand");
    end

    repeat (2) @(negedge CLK);
    chk("scoreboard_drained", 64'(exp_q.size()), 64'(0));
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, %0d miscompares so far", miscompares);
    $fatal(1, "watchdog");
  end

endmodule
